// File: rtl/display_pkg.sv
// Shared constants for the seven-segment display drivers: blank pattern,
// brightness width and the active-low hex glyph table ({CA..CG}).
package display_pkg;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam int BRIGHT_W = 4;
    localparam logic [BRIGHT_W-1:0] BRIGHT_FULL = '1;

    // Entry n is the glyph for hex digit n; bit 6 = CA ... bit 0 = CG, 0 = segment on.
    localparam logic [15:0][6:0] HEX_PATTERN = {
        7'b0111000,  // F
        7'b0110000,  // E
        7'b1000010,  // d
        7'b0110001,  // C
        7'b1100000,  // b
        7'b0001000,  // A
        7'b0000100,  // 9
        7'b0000000,  // 8
        7'b0001111,  // 7
        7'b0100000,  // 6
        7'b0100100,  // 5
        7'b1001100,  // 4
        7'b0000110,  // 3
        7'b0010010,  // 2
        7'b1001111,  // 1
        7'b0000001   // 0
    };

endpackage

// File: rtl/hex_to_seg7.sv
// Combinational hex nibble to active-low 7-segment glyph decoder.
module hex_to_seg7
    import display_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    assign pattern = HEX_PATTERN[nibble];

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed driver for NUM_DIGITS common-anode 7-segment digits.
// Inputs are captured once per frame into shadow registers; each digit gets
// one slot of 2**PRESCALE_W clocks, PWM-dimmed by the upper prescaler bits.
// Optional blinking is enabled by defining SEVEN_SEG_BLINK_EN.
module seven_seg_scanner
    import display_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int PRESCALE_W = 11,
    parameter int BLINK_W    = 6
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   point,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_suppress,
    input  logic [BRIGHT_W-1:0]     brightness,
`ifdef SEVEN_SEG_BLINK_EN
    input  logic [NUM_DIGITS-1:0]   blink,
`endif
    output logic [7:0]              segment,
    output logic [NUM_DIGITS-1:0]   digit,
    output logic                    frame_tick
);

    localparam int INDEX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [INDEX_W-1:0] LAST_INDEX = INDEX_W'(NUM_DIGITS - 1);

    // Reject configurations the PWM slice or the index logic cannot support.
    if (NUM_DIGITS < 2 || NUM_DIGITS > 8 || PRESCALE_W < BRIGHT_W || BLINK_W < 1) begin : g_bad_params
        $error("seven_seg_scanner: unsupported parameter combination");
    end

    logic [PRESCALE_W-1:0]   prescaler;
    logic [INDEX_W-1:0]      index;
    logic                    load_pending;
    logic [4*NUM_DIGITS-1:0] value_shadow;
    logic [NUM_DIGITS-1:0]   point_shadow;
    logic [NUM_DIGITS-1:0]   blank_shadow;

    logic                    slot_end;
    logic                    load;
    logic [3:0]              current_nibble;
    logic [6:0]              current_pattern;
    logic [NUM_DIGITS-1:0]   suppress_vec;
    logic                    pwm_lit;
    logic                    blink_dark;
    logic                    show;
    logic [NUM_DIGITS-1:0]   digit_next;
    logic [7:0]              segment_next;

    assign slot_end = &prescaler;
    assign load     = (slot_end && (index == LAST_INDEX)) || load_pending;

    // Prescaler and digit index advance continuously; index steps at each slot end.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler <= '0;
            index     <= '0;
        end else begin
            prescaler <= prescaler + 1'b1;
            if (slot_end) begin
                index <= (index == LAST_INDEX) ? '0 : index + 1'b1;
            end
        end
    end

    // Snapshot the display inputs at frame boundaries (or right after reset).
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_pending <= 1'b1;
            value_shadow <= '0;
            point_shadow <= '0;
            blank_shadow <= '0;
            frame_tick   <= 1'b0;
        end else begin
            frame_tick <= load;
            if (load) begin
                load_pending <= 1'b0;
                value_shadow <= value;
                point_shadow <= point;
                blank_shadow <= blank;
            end
        end
    end

`ifdef SEVEN_SEG_BLINK_EN
    logic [NUM_DIGITS-1:0] blink_shadow;
    logic [BLINK_W-1:0]    blink_count;

    // Blink mask is captured with the rest of the frame; frame counter sets the phase.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            blink_shadow <= '0;
            blink_count  <= '0;
        end else begin
            if (load) begin
                blink_shadow <= blink;
            end
            if (frame_tick) begin
                blink_count <= blink_count + 1'b1;
            end
        end
    end

    assign blink_dark = blink_count[BLINK_W-1] && blink_shadow[index];
`else
    assign blink_dark = 1'b0;
`endif

    // A digit is a suppressed leading zero when it and all digits above it are zero.
    always_comb begin
        logic above_zero;
        above_zero   = 1'b1;
        suppress_vec = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            above_zero = above_zero && (value_shadow[4*i +: 4] == 4'h0);
            suppress_vec[i] = (i != 0) && lz_suppress && above_zero && !point_shadow[i];
        end
    end

    assign current_nibble = value_shadow[{index, 2'b00} +: 4];

    hex_to_seg7 u_decoder (
        .nibble  (current_nibble),
        .pattern (current_pattern)
    );

    assign pwm_lit = (brightness == BRIGHT_FULL) ||
                     (prescaler[PRESCALE_W-1 -: BRIGHT_W] < brightness);

    assign show = pwm_lit && !blank_shadow[index] && !suppress_vec[index] && !blink_dark;

    // Build the next anode and cathode patterns for the current slot.
    always_comb begin
        digit_next   = '1;
        segment_next = SEG_BLANK;
        if (show) begin
            digit_next[index] = 1'b0;
            segment_next      = {current_pattern, ~point_shadow[index]};
        end
    end

    // Register the pin drivers so the board sees glitch-free outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            digit   <= '1;
            segment <= SEG_BLANK;
        end else begin
            digit   <= digit_next;
            segment <= segment_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Directed self-checking bench for seven_seg_scanner (4 digits, 16-clock slots).
// Blink behaviour is exercised when SEVEN_SEG_BLINK_EN is defined.
module tb_seven_seg_scanner;

    logic        clock;
    logic        reset;
    logic [15:0] value;
    logic [3:0]  point;
    logic [3:0]  blank;
    logic        lz_suppress;
    logic [3:0]  brightness;
    logic [3:0]  blink;
    logic [7:0]  segment;
    logic [3:0]  digit;
    logic        frame_tick;

    int errors = 0;
    int checks = 0;
    int edgeCount = 0;
    int lowCount;

    seven_seg_scanner #(
        .NUM_DIGITS (4),
        .PRESCALE_W (4),
        .BLINK_W    (2)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .value       (value),
        .point       (point),
        .blank       (blank),
        .lz_suppress (lz_suppress),
        .brightness  (brightness),
`ifdef SEVEN_SEG_BLINK_EN
        .blink       (blink),
`endif
        .segment     (segment),
        .digit       (digit),
        .frame_tick  (frame_tick)
    );

    // 10 ns clock.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Number of rising edges since reset was released.
    always @(posedge clock) begin
        if (reset) edgeCount = 0;
        else edgeCount = edgeCount + 1;
    end

    // Advance to just after the given edge number.
    task automatic applyStimulus(input int target);
        int guard;
        guard = 0;
        while (edgeCount < target && guard < 2000) begin
            @(posedge clock);
            #1;
            guard++;
        end
    endtask

    // Compare anode and segment outputs.
    task automatic checkOutput(input string tag, input logic [3:0] expDigit, input logic [7:0] expSeg);
        checks++;
        assert (digit === expDigit) else begin
            errors++;
            $error("[TB] FAIL %s digit got %b expected %b", tag, digit, expDigit);
        end
        checks++;
        assert (segment === expSeg) else begin
            errors++;
            $error("[TB] FAIL %s segment got %h expected %h", tag, segment, expSeg);
        end
    endtask

    // Compare the frame tick pulse.
    task automatic checkTick(input string tag, input logic expTick);
        checks++;
        assert (frame_tick === expTick) else begin
            errors++;
            $error("[TB] FAIL %s frame_tick got %b expected %b", tag, frame_tick, expTick);
        end
    endtask

    initial begin
        reset = 1'b0;
        value = 16'h1230;
        point = 4'b0000;
        blank = 4'b0000;
        lz_suppress = 1'b0;
        brightness = 4'd15;
        blink = 4'b0000;
        #1 reset = 1'b1;
        #2;
        checkOutput("reset", 4'b1111, 8'hFF);
        checkTick("reset_tick", 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;

        // First slot of the first frame, then digit advance.
        applyStimulus(1);
        checkOutput("first_slot", 4'b1110, 8'h03);
        checkTick("first_tick", 1'b1);
        applyStimulus(2);
        checkTick("tick_one_cycle", 1'b0);
        applyStimulus(16);
        checkOutput("slot0_end", 4'b1110, 8'h03);
        applyStimulus(17);
        checkOutput("slot1_start", 4'b1101, 8'h0D);

        // Mid-frame change is held off until the next snapshot.
        value = 16'h4567;
        applyStimulus(33);
        checkOutput("hold_d2", 4'b1011, 8'h25);
        applyStimulus(49);
        checkOutput("hold_d3", 4'b0111, 8'h9F);
        applyStimulus(63);
        checkTick("no_tick_early", 1'b0);
        applyStimulus(64);
        checkTick("frame_tick", 1'b1);
        checkOutput("last_old", 4'b0111, 8'h9F);
        applyStimulus(65);
        checkOutput("new_frame_d0", 4'b1110, 8'h1F);

        // Leading-zero suppression.
        value = 16'h0005;
        lz_suppress = 1'b1;
        applyStimulus(129);
        checkOutput("lz_d0", 4'b1110, 8'h49);
        applyStimulus(145);
        checkOutput("lz_d1", 4'b1111, 8'hFF);
        applyStimulus(161);
        checkOutput("lz_d2", 4'b1111, 8'hFF);
        applyStimulus(177);
        checkOutput("lz_d3", 4'b1111, 8'hFF);

        // PWM at brightness 4: lit for prescaler 0..3 only.
        brightness = 4'd4;
        applyStimulus(193);
        checkOutput("pwm_first", 4'b1110, 8'h49);
        applyStimulus(196);
        checkOutput("pwm_last_lit", 4'b1110, 8'h49);
        applyStimulus(197);
        checkOutput("pwm_dark", 4'b1111, 8'hFF);

        // Brightness 0 keeps every anode off; next frame inputs staged meanwhile.
        brightness = 4'd0;
        value = 16'h1234;
        point = 4'b0010;
        blank = 4'b0001;
        lz_suppress = 1'b0;
        blink = 4'b0100;
        lowCount = 0;
        for (int i = 0; i < 59; i++) begin
            applyStimulus(edgeCount + 1);
            if (digit !== 4'b1111) lowCount++;
        end
        checks++;
        assert (lowCount == 0) else begin
            errors++;
            $error("[TB] FAIL bright0 low_cycles got %0d expected 0", lowCount);
        end

        // Decimal point and blanking.
        brightness = 4'd15;
        applyStimulus(257);
        checkOutput("blank_d0", 4'b1111, 8'hFF);
        applyStimulus(273);
        checkOutput("point_d1", 4'b1101, 8'h0C);
        applyStimulus(289);
        checkOutput("blink_off_phase", 4'b1011, 8'h25);
        applyStimulus(353);
`ifdef SEVEN_SEG_BLINK_EN
        checkOutput("blink_on_phase", 4'b1111, 8'hFF);
`else
        checkOutput("no_blink", 4'b1011, 8'h25);
`endif

        // Reset in the middle of a lit slot darkens outputs immediately.
        applyStimulus(355);
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_reset", 4'b1111, 8'hFF);
        checkTick("mid_reset_tick", 1'b0);
        @(posedge clock);
        #1 reset = 1'b0;
        applyStimulus(1);
        checkOutput("reset_first_slot", 4'b1110, 8'h03);
        checkTick("reset_reload_tick", 1'b1);
        applyStimulus(2);
        checkOutput("reset_blank_d0", 4'b1111, 8'hFF);
        applyStimulus(17);
        checkOutput("reset_reload_d1", 4'b1101, 8'h0C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
